// File: rtl/line_memory_responder_pkg.sv
// Shared definitions for the dcache <-> memory line interface: widths, FSM encoding
// and the address-to-line mapping used by both ends of the link.
package line_mem_pkg;

  localparam int LINE_W      = 256;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_NUM_W  = ADDR_W - OFFSET_BITS;
  localparam int CNT_W       = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Full line number, not truncated to the array depth, so callers can range-check it.
  function automatic logic [LINE_NUM_W-1:0] line_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/line_memory_responder_if.sv
// Request/response bundle between the dcache (master) and the line memory (slave).
interface line_memory_responder_if;
  import line_mem_pkg::*;

  logic                  enable_i;
  logic                  write_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [LINE_W-1:0]     data_i;
  logic                  ack_o;
  logic [LINE_W-1:0]     data_o;
  logic                  err_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o, err_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o, err_o
  );

endinterface

// File: rtl/line_memory_responder_counter.sv
// Latency down-counter: load on request acceptance, decrement while waiting,
// flag the last wait cycle when the count sits at one.
module mem_latency_counter
  import line_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/line_memory_responder.sv
// Memory end of the dcache line link: one outstanding request, fixed-latency ack.
// state | meaning:  IDLE | sample enable  ;  WAIT | latency count  ;  ACK | ack_o pulse
module line_memory_responder
  import line_mem_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input logic                    clk_i,
  input logic                    rst_i,
  line_memory_responder_if.slave bus
);

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [LINE_NUM_W-1:0] DEPTH_LN = LINE_NUM_W'(DEPTH);

  if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
    $error("line_memory_responder: LATENCY must be within 1..255");
  end

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  accept;
  logic                  go_ack;
  logic                  cnt_done;

  logic [LINE_NUM_W-1:0] in_line;
  logic                  in_oor;
  logic [IDX_W-1:0]      in_idx;

  logic                  lat_write;
  logic                  lat_oor;
  logic [IDX_W-1:0]      lat_idx;
  logic [LINE_W-1:0]     lat_data;

  logic                  cmt_write;
  logic                  cmt_oor;
  logic [IDX_W-1:0]      cmt_idx;
  logic [LINE_W-1:0]     cmt_data;

  assign in_line = line_idx(bus.addr_i);
  assign in_oor  = (in_line >= DEPTH_LN);
  assign in_idx  = in_line[IDX_W-1:0];
  assign accept  = (state == ST_IDLE) && bus.enable_i;

  mem_latency_counter u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (accept),
    .load_val (CNT_LOAD),
    .dec      (state == ST_WAIT),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.enable_i) state_nxt = (LATENCY == 1) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (cnt_done)     state_nxt = ST_ACK;
      ST_ACK:                    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  assign go_ack = (state_nxt == ST_ACK);

  // With a one-cycle latency the commit happens on the accepting edge, so the live
  // request is used; otherwise the copy latched at acceptance.
  always_comb begin
    cmt_write = lat_write;
    cmt_oor   = lat_oor;
    cmt_idx   = lat_idx;
    cmt_data  = lat_data;
    if (state == ST_IDLE) begin
      cmt_write = bus.write_i;
      cmt_oor   = in_oor;
      cmt_idx   = in_idx;
      cmt_data  = bus.data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      lat_write  <= 1'b0;
      lat_oor    <= 1'b0;
      lat_idx    <= '0;
      lat_data   <= '0;
      bus.ack_o  <= 1'b0;
      bus.err_o  <= 1'b0;
      bus.data_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_write <= bus.write_i;
        lat_oor   <= in_oor;
        lat_idx   <= in_idx;
        lat_data  <= bus.data_i;
      end
      bus.ack_o <= go_ack;
      bus.err_o <= go_ack && cmt_oor;
      if (go_ack && !cmt_write) begin
        bus.data_o <= cmt_oor ? '0 : memory[cmt_idx];
      end
    end
  end

  // Array kept in its own unreset block so its contents survive reset and stay
  // reachable for preload/flush from outside.
  always @(posedge clk_i) begin
    if (go_ack && cmt_write && !cmt_oor && !rst_i) begin
      memory[cmt_idx] <= cmt_data;
    end
  end

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: a LATENCY=10 instance and a LATENCY=1 instance
// checked against a line-array reference model with randomized traffic.
module tb_line_memory_responder;
  import line_mem_pkg::*;

  localparam int L0 = 10;
  localparam int NL = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_memory_responder_if bus0 ();
  line_memory_responder_if bus1 ();

  line_memory_responder #(.DEPTH(NL), .LATENCY(L0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  line_memory_responder #(.DEPTH(NL), .LATENCY(1))  dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  logic [255:0] mem_model [0:NL-1];
  logic [255:0] last_rd;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive(input bit sel, input logic en, input logic w, input logic [31:0] a,
                       input logic [255:0] d);
    if (sel) begin
      bus1.enable_i = en; bus1.write_i = w; bus1.addr_i = a; bus1.data_i = d;
    end else begin
      bus0.enable_i = en; bus0.write_i = w; bus0.addr_i = a; bus0.data_i = d;
    end
  endtask

  // One request; cyc = posedges from the request cycle until ack (-1 on timeout).
  task automatic xfer(input bit sel, input logic w, input logic [31:0] a, input logic [255:0] d,
                      output int cyc, output logic [255:0] dout, output logic err,
                      output logic ack_next);
    logic ack;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    cyc = 0;
    ack = 1'b0;
    while (!ack && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      ack = sel ? bus1.ack_o : bus0.ack_o;
    end
    dout = sel ? bus1.data_o : bus0.data_o;
    err  = sel ? bus1.err_o : bus0.err_o;
    drive(sel, 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk); #1;
    ack_next = sel ? bus1.ack_o : bus0.ack_o;
    if (!ack) cyc = -1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    rst = 1'b1;
    for (int i = 0; i < NL; i++) begin
      mem_model[i] = rand_line();
      dut0.memory[i] = mem_model[i];
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus0.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus0.ack_o); end
    n_cmp++; if (bus0.err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus0.err_o); end
    n_cmp++; if (bus0.data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus0.data_o); end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus0.ack_o !== 1'b0) begin n_bad++; $display("FAIL idle_ack: got %b want 0", bus0.ack_o); end
    last_rd = '0;
  endtask

  task automatic test_read();
    int cyc; logic [255:0] dout; logic err, an;
    mem_model[0] = 256'h5;
    dut0.memory[0] = 256'h5;
    xfer(0, 1'b0, 32'h0, '0, cyc, dout, err, an);
    n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", cyc, L0); end
    n_cmp++; if (dout !== 256'h5) begin n_bad++; $display("FAIL read_data: got %h want 5", dout); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", err); end
    n_cmp++; if (an !== 1'b0) begin n_bad++; $display("FAIL read_ack_width: got %b want 0", an); end
    last_rd = 256'h5;
  endtask

  task automatic test_reset_mid_wait();
    int acks = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0, rand_line());
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, '0);
    @(negedge clk) rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus0.ack_o) acks++;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL abort_ack: got %0d acks want 0", acks); end
    n_cmp++; if (dut0.memory[0] !== mem_model[0]) begin n_bad++; $display("FAIL abort_mem0: got %h want %h", dut0.memory[0], mem_model[0]); end
    n_cmp++; if (bus0.data_o !== '0) begin n_bad++; $display("FAIL abort_data: got %h want 0", bus0.data_o); end
    last_rd = '0;
  endtask

  task automatic test_write_read();
    int cyc; logic [255:0] dout, d; logic err, an;
    d = {32{8'hA5}};
    xfer(0, 1'b1, 32'h400, d, cyc, dout, err, an);
    mem_model[32'h400 >> 5] = d;
    n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL wr_latency: got %0d want %0d", cyc, L0); end
    n_cmp++; if (dout !== last_rd) begin n_bad++; $display("FAIL wr_data_hold: got %h want %h", dout, last_rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", err); end
    n_cmp++; if (dut0.memory[32] !== d) begin n_bad++; $display("FAIL wr_mem32: got %h want %h", dut0.memory[32], d); end
    xfer(0, 1'b0, 32'h41F, '0, cyc, dout, err, an);
    n_cmp++; if (dout !== mem_model[32'h41F >> 5]) begin n_bad++; $display("FAIL rd_back: got %h want %h", dout, mem_model[32'h41F >> 5]); end
    n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL rd_back_latency: got %0d want %0d", cyc, L0); end
    last_rd = mem_model[32];
  endtask

  task automatic test_out_of_range();
    int cyc, diffs; logic [255:0] dout; logic err, an;
    xfer(0, 1'b0, 32'h4000, '0, cyc, dout, err, an);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b want 1", err); end
    n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL oor_rd_data: got %h want 0", dout); end
    n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL oor_rd_latency: got %0d want %0d", cyc, L0); end
    last_rd = '0;
    xfer(0, 1'b1, 32'h4000, rand_line(), cyc, dout, err, an);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b want 1", err); end
    n_cmp++; if (an !== 1'b0) begin n_bad++; $display("FAIL oor_wr_ack_width: got %b want 0", an); end
    diffs = 0;
    for (int i = 0; i < NL; i++) if (dut0.memory[i] !== mem_model[i]) diffs++;
    n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL oor_wr_mem: got %0d changed lines want 0", diffs); end
  endtask

  task automatic test_back_to_back();
    int acks = 0, first = -1, second = -1;
    logic [255:0] got1 = '0, got2 = '0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd7 << 5, '0);
    for (int e = 1; e <= 2 * L0 + 12; e++) begin
      @(posedge clk); #1;
      if (bus0.ack_o) begin
        acks++;
        if (acks == 1) begin
          first = e; got1 = bus0.data_o;
          bus0.addr_i = 32'd9 << 5;
        end else if (acks == 2) begin
          second = e; got2 = bus0.data_o;
          bus0.enable_i = 1'b0;
        end
      end
    end
    // request period = L0 cycles to ack plus the one IDLE cycle that re-samples enable
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", acks); end
    n_cmp++; if (first != L0) begin n_bad++; $display("FAIL b2b_first: got %0d want %0d", first, L0); end
    n_cmp++; if (second != 2 * L0 + 1) begin n_bad++; $display("FAIL b2b_second: got %0d want %0d", second, 2 * L0 + 1); end
    n_cmp++; if (got1 !== mem_model[7]) begin n_bad++; $display("FAIL b2b_data1: got %h want %h", got1, mem_model[7]); end
    n_cmp++; if (got2 !== mem_model[9]) begin n_bad++; $display("FAIL b2b_data2: got %h want %h", got2, mem_model[9]); end
    last_rd = mem_model[9];
  endtask

  task automatic test_enable_drop();
    int cyc = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, (32'd5 << 5) | 32'd3, '0);
    while (!bus0.ack_o && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) bus0.enable_i = 1'b0;
    end
    n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL drop_latency: got %0d want %0d", cyc, L0); end
    n_cmp++; if (bus0.data_o !== mem_model[5]) begin n_bad++; $display("FAIL drop_data: got %h want %h", bus0.data_o, mem_model[5]); end
    bus0.enable_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus0.ack_o !== 1'b0) begin n_bad++; $display("FAIL drop_ack_width: got %b want 0", bus0.ack_o); end
    last_rd = mem_model[5];
  endtask

  task automatic test_random();
    int cyc, ln, diffs; logic [255:0] dout, d, exp; logic err, an, w, exp_err; logic [31:0] a;
    for (int t = 0; t < 24; t++) begin
      w = 1'($urandom_range(0, 1));
      ln = $urandom_range(0, 599);
      a = (32'(ln) << 5) | 32'($urandom_range(0, 31));
      d = rand_line();
      exp_err = (ln >= NL);
      xfer(0, w, a, d, cyc, dout, err, an);
      n_cmp++; if (cyc != L0) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, cyc, L0); end
      n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", t, err, exp_err); end
      n_cmp++; if (an !== 1'b0) begin n_bad++; $display("FAIL rnd_ack_width[%0d]: got %b want 0", t, an); end
      if (w) begin
        exp = last_rd;
        if (!exp_err) mem_model[ln] = d;
      end else begin
        exp = exp_err ? '0 : mem_model[ln];
        last_rd = exp;
      end
      n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", t, dout, exp); end
    end
    diffs = 0;
    for (int i = 0; i < NL; i++) if (dut0.memory[i] !== mem_model[i]) diffs++;
    n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL rnd_mem: got %0d differing lines want 0", diffs); end
  endtask

  task automatic test_latency1();
    int cyc; logic [255:0] dout, v, w; logic err, an;
    v = rand_line();
    w = rand_line();
    dut1.memory[3] = v;
    xfer(1, 1'b0, (32'd3 << 5) | 32'd7, '0, cyc, dout, err, an);
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL l1_rd_latency: got %0d want 1", cyc); end
    n_cmp++; if (dout !== v) begin n_bad++; $display("FAIL l1_rd_data: got %h want %h", dout, v); end
    n_cmp++; if (an !== 1'b0) begin n_bad++; $display("FAIL l1_ack_width: got %b want 0", an); end
    xfer(1, 1'b1, 32'd4 << 5, w, cyc, dout, err, an);
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL l1_wr_latency: got %0d want 1", cyc); end
    n_cmp++; if (dout !== v) begin n_bad++; $display("FAIL l1_wr_data_hold: got %h want %h", dout, v); end
    n_cmp++; if (dut1.memory[4] !== w) begin n_bad++; $display("FAIL l1_wr_mem: got %h want %h", dut1.memory[4], w); end
    xfer(1, 1'b0, 32'd4 << 5, '0, cyc, dout, err, an);
    n_cmp++; if (dout !== w) begin n_bad++; $display("FAIL l1_rd_back: got %h want %h", dout, w); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_reset_mid_wait();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_enable_drop();
    test_random();
    test_latency1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
